// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one external 32-bit ALU between two requesters. A round-robin
// arbiter picks a winner in IDLE, the winner's operands and ALUControl code
// are latched and presented to the ALU for one EXEC cycle, and the ALU
// Result/Zero are registered and returned to the winner in RESP over a
// valid/ready handshake.
//
// Build option: define ALU_ILLEGAL_OP_CHECK_EN to add resp0_err/resp1_err.
// With it, unsupported ALUControl codes bypass the ALU and are answered
// directly with result=0, zero=0, err=1.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  // response 0
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_zero,
  // response 1
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_zero,
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  output logic             resp0_err,
  output logic             resp1_err,
`endif
  // external ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // arbitration state
  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;

  // operands latched on accept; these also drive the ALU
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [OPW-1:0]   opc_q, opc_d;

  // per-port response registers
  logic [WIDTH-1:0] res0_q, res0_d;
  logic [WIDTH-1:0] res1_q, res1_d;
  logic             zero0_q, zero0_d;
  logic             zero1_q, zero1_d;
  logic             vld0_q, vld0_d;
  logic             vld1_q, vld1_d;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  logic             err0_q, err0_d;
  logic             err1_q, err1_d;
`endif

  // arbitration / selection helpers
  logic             grant_sel;
  logic             accept;
  logic             owner_ready;
  logic             skip_exec;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OPW-1:0]   sel_op;

`ifdef ALU_ILLEGAL_OP_CHECK_EN
  // Only AND, OR, ADD, SUB and SLT are implemented by the ALU.
  function automatic logic is_illegal(input logic [OPW-1:0] op);
    case (op)
      OPW'(0), OPW'(1), OPW'(2), OPW'(6), OPW'(7): is_illegal = 1'b0;
      default:                                     is_illegal = 1'b1;
    endcase
  endfunction
`endif

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant_q;
    end else begin
      grant_sel = ~req0_valid;
    end
    sel_a  = grant_sel ? req1_a  : req0_a;
    sel_b  = grant_sel ? req1_b  : req0_b;
    sel_op = grant_sel ? req1_op : req0_op;
  end

  // Ready is offered only in IDLE, only to the granted requester, never during reset.
  always_comb begin
    req0_ready = !reset && (state_q == IDLE) && req0_valid && !grant_sel;
    req1_ready = !reset && (state_q == IDLE) && req1_valid &&  grant_sel;
    accept     = req0_ready || req1_ready;
    owner_ready = owner_q ? resp1_ready : resp0_ready;
  end

  // Next-state and next-register computation for the IDLE -> EXEC -> RESP flow.
  always_comb begin
    // NOTE: every *_d gets its hold value first so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    opc_d        = opc_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    zero0_d      = zero0_q;
    zero1_d      = zero1_q;
    vld0_d       = vld0_q;
    vld1_d       = vld1_q;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    err0_d       = err0_q;
    err1_d       = err1_q;
`endif
    skip_exec    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = grant_sel;
          last_grant_d = grant_sel;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
          skip_exec    = is_illegal(sel_op);
          if (grant_sel) begin
            err1_d = skip_exec;
          end else begin
            err0_d = skip_exec;
          end
`endif
          if (skip_exec) begin
            // Unsupported code: answer at once, leave the ALU inputs untouched.
            state_d = RESP;
            if (grant_sel) begin
              res1_d  = '0;
              zero1_d = 1'b0;
              vld1_d  = 1'b1;
            end else begin
              res0_d  = '0;
              zero0_d = 1'b0;
              vld0_d  = 1'b1;
            end
          end else begin
            opa_d   = sel_a;
            opb_d   = sel_b;
            opc_d   = sel_op;
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        // The ALU has seen the latched operands for a full cycle; capture it.
        if (owner_q) begin
          res1_d  = alu_result;
          zero1_d = alu_zero;
          vld1_d  = 1'b1;
        end else begin
          res0_d  = alu_result;
          zero0_d = alu_zero;
          vld0_d  = 1'b1;
        end
        state_d = RESP;
      end

      RESP: begin
        // Hold the response until the owner takes it, then return to IDLE.
        if (owner_ready) begin
          vld0_d  = 1'b0;
          vld1_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      opc_q        <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
      zero0_q      <= 1'b0;
      zero1_q      <= 1'b0;
      vld0_q       <= 1'b0;
      vld1_q       <= 1'b0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      opc_q        <= opc_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      zero0_q      <= zero0_d;
      zero1_q      <= zero1_d;
      vld0_q       <= vld0_d;
      vld1_q       <= vld1_d;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      err0_q       <= err0_d;
      err1_q       <= err1_d;
`endif
    end
  end

  // Registered outputs
  assign alu_a        = opa_q;
  assign alu_b        = opb_q;
  assign alu_ctrl     = opc_q;
  assign resp0_valid  = vld0_q;
  assign resp0_result = res0_q;
  assign resp0_zero   = zero0_q;
  assign resp1_valid  = vld1_q;
  assign resp1_result = res1_q;
  assign resp1_zero   = zero1_q;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  assign resp0_err    = err0_q;
  assign resp1_err    = err1_q;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters, e.g. the main datapath and an address/branch-compare unit.
- Arbitrates round-robin and latches the winner's operands and ALUControl code.
- Drives the external ALU instance for one cycle and registers its Result/Zero.
- Returns the response to the granted requester over a valid/ready handshake.

Parameters:
WIDTH, 32, operand/result width; must match the ALU instance.
OPW, 4, ALUControl code width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_a, req0_b  in  WIDTH  requester 0 operands.
req0_op  in  OPW  requester 0 ALUControl code.
req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
resp0_valid  out  1  result for requester 0 available.
resp0_ready  in  1  requester 0 consumes the result.
resp0_result  out  WIDTH  registered ALU Result.
resp0_zero  out  1  registered ALU Zero.
resp1_valid, resp1_ready, resp1_result, resp1_zero: same as requester 0, for requester 1.
alu_a, alu_b  out  WIDTH  to ALU A/B.
alu_ctrl  out  OPW  to ALU ALUControl.
alu_result  in  WIDTH  from ALU Result.
alu_zero  in  1  from ALU Zero.

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous and active-high.
- States: IDLE, EXEC, RESP. State register and last_grant are the only arbitration state.
- Reset (async, any state):
  - state=IDLE, last_grant=1 so requester 0 wins the first tie.
  - Operand registers, result registers and owner reset to 0.
  - resp*_valid=0, resp*_result=0, resp*_zero=0; alu_a/alu_b/alu_ctrl=0.
  - req*_ready forced 0 while reset is high.
  - An operation in flight when reset asserts is discarded; no response is issued.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, it goes to the requester != last_grant.
  - reqN_ready=1 combinationally only for the granted requester; all ready outputs are 0 outside IDLE.
  - On valid&ready: latch a/b/op, set owner=N, last_grant=N, go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_ctrl driven from the latched registers; they hold those values in every state until the next accept.
  - At the clock edge: capture alu_result/alu_zero into the response registers and go to RESP.
- RESP:
  - resp<owner>_valid=1; the other resp_valid stays 0.
  - Result and zero held stable until resp<owner>_ready=1.
  - On that handshake edge: valid drops to 0 and state returns to IDLE.
  - No new request is accepted in the same cycle.
- Latency: accept at edge T, resp_valid high from edge T+2. Minimum period between accepts is 3 cycles.
- Requester rules: valid, a, b and op must hold until ready; the arbiter samples operands only on the accept edge.
- Simultaneous events:
  - A requester whose valid drops before grant is simply not served; no state change.
  - Both valid on consecutive ops → strict alternation 0,1,0,1.
- Widths: no arithmetic inside the block; results pass through unchanged at WIDTH bits.

Optional Feature:
Macro ALU_ILLEGAL_OP_CHECK_EN.
- Defined:
  - Adds outputs resp0_err and resp1_err (1 bit each, reset 0).
  - Legal codes: 0000, 0001, 0010, 0110, 0111.
  - Accepting any other code skips EXEC and goes IDLE→RESP directly (resp_valid from T+1), with result=0, zero=0, err=1; alu_* outputs are not updated.
  - Legal ops respond with err=0.
- Undefined:
  - Ports absent; every code is forwarded to the ALU.
  - An unsupported code therefore returns the ALU's default result 0 with zero=1.

Test Plan:
1. Reset mid-EXEC (req0 accepted, reset pulsed for 1 cycle) → state IDLE, resp0_valid stays 0, and a subsequent simultaneous req0/req1 grants req0 first.
2. req0 only, a=7, b=5, op=0110 → req0_ready=1 at T, resp0_valid=1 at T+2 with result=2, zero=0. Hold resp0_ready=0 for 4 cycles → values stable.
3. req0 and req1 both valid continuously, four ops each (op=0010, a=i, b=1) → grants alternate 0,1,0,1…, each response goes to the correct port only, and accepts occur every 3 cycles.
4. req1 a=9, b=9, op=0110 → resp1_result=0, resp1_zero=1. Then a=3, b=9, op=0111 → result=1, zero=0.
5. resp0_ready held high before resp0_valid rises → single-cycle resp0_valid pulse, then IDLE. A req1 pending throughout is accepted the following cycle.
6. op=1111 → with ALU_ILLEGAL_OP_CHECK_EN: resp_valid at T+1, err=1, result=0, zero=0. Without: resp_valid at T+2, result=0, zero=1.
